// File: rtl/inv_subbytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_subbytes_seq (with sbox_LUT_decrypt)
// Brief    : Multi-cycle AES InvSubBytes engine. LANES inverse S-box copies
//            substitute the 16 state bytes in place, LANES bytes per cycle,
//            behind valid/ready handshakes on both sides.
// Options  : INV_SUBBYTES_ABORT_EN adds a synchronous 'abort' input that
//            returns the engine to IDLE from BUSY or DONE.
// Revision : 1.0 - initial release
// ============================================================================

// Combinational AES inverse S-box lookup.
module sbox_LUT_decrypt (
   input  logic [7:0] addr,
   output logic [7:0] data
);

   // Element 0 is the leftmost byte of the concatenation.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign data = INV_SBOX[addr];

endmodule

module inv_subbytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
`ifdef INV_SUBBYTES_ABORT_EN
   ,
   input  logic         abort
`endif
);

   localparam int STEPS  = 16 / LANES;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Only divisors of 16 give a whole number of substitution steps.
   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   logic [1:0]        state;
   logic [STEP_W-1:0] step;
   // Byte 0 (index 0) maps to bits [127:120], matching the port byte order.
   logic [0:15][7:0]  buffer;
   logic [3:0]        lane_idx [LANES];
   logic [7:0]        lane_in  [LANES];
   logic [7:0]        lane_out [LANES];
   logic              last_step;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_BUSY);
   assign out_data  = buffer;
   assign last_step = (step == STEP_W'(STEPS - 1));

   // Select the LANES consecutive buffer bytes addressed by the current step.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_idx[k] = 4'(int'(step) * LANES + k);
         lane_in[k]  = buffer[lane_idx[k]];
      end
   end

   generate
      for (genvar g = 0; g < LANES; g++) begin : g_lane
         sbox_LUT_decrypt u_sbox (
            .addr (lane_in[g]),
            .data (lane_out[g])
         );
      end
   endgenerate

   // Control FSM and in-place substitution of the state buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         step   <= '0;
         buffer <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  buffer <= in_data;
                  step   <= '0;
                  state  <= S_BUSY;
               end
            end
            S_BUSY: begin
`ifdef INV_SUBBYTES_ABORT_EN
               if (abort) begin
                  // Partially substituted contents stay in the buffer.
                  step  <= '0;
                  state <= S_IDLE;
               end else
`endif
               begin
                  for (int k = 0; k < LANES; k++) begin
                     buffer[lane_idx[k]] <= lane_out[k];
                  end
                  if (last_step) begin
                     step  <= '0;
                     state <= S_DONE;
                  end else begin
                     step  <= step + 1'b1;
                  end
               end
            end
            S_DONE: begin
`ifdef INV_SUBBYTES_ABORT_EN
               if (abort) begin
                  step  <= '0;
                  state <= S_IDLE;
               end else
`endif
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               step  <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
